// File: rtl/uart_pkg.sv
// Shared definitions for the word-stream UART transmitter.
//   tx_state_e     : transmitter FSM states (PARITY is only reachable when
//                    the design is built with UART_TX_PARITY_EN defined)
//   UART_DATA_BITS : data bits per character
//   parity_bit()   : parity of one character, even (odd=0) or odd (odd=1)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity makes the total count of ones (data + parity) even.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                      input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with first-word fall-through read port.
// Ports:
//   clk    in   single clock, posedge
//   reset  in   synchronous, active-low; empties the FIFO
//   push   in   write wdata at this edge (ignored while full)
//   pop    in   drop the head word at this edge (ignored while empty)
//   wdata  in   WIDTH  word to write
//   rdata  out  WIDTH  head word, valid combinationally while !empty
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  $clog2(DEPTH)+1  words held (registered)
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset: contents are unobservable while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_word_stream.sv
// UART 8N1/8N2 transmitter that streams multi-byte words off-chip.
// Words are buffered in a FIFO and sent LSB byte first, LSB bit first, with
// no idle gap between bytes of a word or between back-to-back words.
// Optional feature macro: UART_TX_PARITY_EN adds one parity bit per byte
// (even when PARITY_ODD=0, odd when PARITY_ODD=1).
// Ports:
//   clk         in   single clock, posedge
//   reset       in   synchronous, active-low
//   in_data     in   8*WORD_BYTES  word to send
//   in_valid    in   word present
//   in_ready    out  FIFO not full
//   tx          out  serial line, idles high, driven from a flop
//   busy        out  FSM not idle or FIFO non-empty
//   word_done   out  one-cycle pulse after the last stop bit of a word
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered
// Handshake: a word transfers at a posedge where in_valid && in_ready are
// both high; in_ready depends only on the registered FIFO count, so it never
// depends on in_valid and stays low while full even if a pop happens.
module uart_tx_word_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_BYTES   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          word_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_word_bytes
    $error("WORD_BYTES must be in 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  // FIFO
  logic          fifo_push;
  logic          fifo_pop;
  logic [WW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  assign fifo_push = in_valid && in_ready;

  uart_word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serialiser state
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;     // data bit index in DATA, stop bit index in STOP
  logic [IW-1:0] byte_q, byte_d;
  logic [WW-1:0] shift_q, shift_d; // current byte always sits in [7:0]
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and datapath. tx_d is the line level for the bit that starts
  // at the coming edge, so every bit boundary coincides with a baud wrap.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_wrap ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          byte_d   = '0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end

      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
`ifdef UART_TX_PARITY_EN
          par_d   = parity_bit(shift_q[UART_DATA_BITS-1:0], PARITY_ODD[0]);
`endif
        end
      end

      DATA: begin
        if (baud_wrap) begin
          // One shift per bit: after eight, the next byte is at the bottom.
          shift_d = shift_q >> 1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_wrap) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            if (byte_q != IW'(WORD_BYTES - 1)) begin
              byte_d  = byte_q + 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              done_d = 1'b1;
              // Chain straight into the next word to avoid an idle gap.
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_rdata;
                byte_d   = '0;
                state_d  = START;
                tx_d     = 1'b0;
              end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
              end
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign word_done = done_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign in_ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_word_stream.sv
// Bench for uart_tx_word_stream: dut0 uses STOP_BITS=1, dut1 uses STOP_BITS=2,
// both CLKS_PER_BIT=4, WORD_BYTES=4, FIFO_DEPTH=4. Parity checks are active
// when the bundle is built with UART_TX_PARITY_EN.
module tb_uart_tx_word_stream;

  localparam int C    = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME0 = (10 + PAR) * C;
  localparam int FRAME1 = (11 + PAR) * C;
  localparam int WORD0  = 4 * FRAME0;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0 (one stop bit)
  logic [31:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, tx, busy, word_done;
  logic [2:0]  fifo_count;

  // dut1 (two stop bits)
  logic [31:0] in_data1  = '0;
  logic        in_valid1 = 1'b0;
  logic        in_ready1, tx1, busy1, word_done1;
  logic [2:0]  fifo_count1;

  uart_tx_word_stream #(
    .CLKS_PER_BIT (C), .WORD_BYTES (4), .FIFO_DEPTH (4),
    .STOP_BITS (1), .PARITY_ODD (PODD)
  ) dut0 (
    .clk (clk), .reset (reset), .in_data (in_data), .in_valid (in_valid),
    .in_ready (in_ready), .tx (tx), .busy (busy), .word_done (word_done),
    .fifo_count (fifo_count)
  );

  uart_tx_word_stream #(
    .CLKS_PER_BIT (C), .WORD_BYTES (4), .FIFO_DEPTH (4),
    .STOP_BITS (2), .PARITY_ODD (PODD)
  ) dut1 (
    .clk (clk), .reset (reset), .in_data (in_data1), .in_valid (in_valid1),
    .in_ready (in_ready1), .tx (tx1), .busy (busy1), .word_done (word_done1),
    .fifo_count (fifo_count1)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] rx_byte_q[$];
  int         rx_cyc_q[$];
  logic       rx_par_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", (n < 400), 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_tx_start(output int s);
    int n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_wait", (n < 50), 1'b1);
    s = cyc;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", (n < limit), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_neg(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (reset !== 1'b1) ab = 1'b1;
    end
  endtask

  function automatic logic exp_bit1(input logic [31:0] w, input int off);
    int         b   = off / FRAME1;
    int         pos = (off % FRAME1) / C;
    logic [7:0] by  = w[8*b +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return by[pos-1];
    if (PAR == 1 && pos == 9) return (PODD != 0) ? ~^by : ^by;
    return 1'b1;
  endfunction

  // serial receiver for dut0, samples each bit in its middle
  initial begin : rx_mon
    logic [7:0] b;
    logic       ab;
    logic       p;
    int         st;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        st = cyc;
        ab = 1'b0;
        p  = 1'b0;
        b  = '0;
        wait_neg(C / 2, ab);
        if (!ab) check("rx_start_mid", tx, 1'b0);
        for (int j = 0; j < 8; j++) begin
          wait_neg(C, ab);
          b[j] = tx;
        end
`ifdef UART_TX_PARITY_EN
        wait_neg(C, ab);
        p = tx;
`endif
        wait_neg(C, ab);
        if (!ab) begin
          check("rx_stop", tx, 1'b1);
          check("rx_expected_present", (exp_q.size() != 0), 1'b1);
          if (exp_q.size() != 0) check("rx_byte", b, exp_q.pop_front());
`ifdef UART_TX_PARITY_EN
          check("rx_parity", p, (PODD != 0) ? ~^b : ^b);
`endif
          rx_byte_q.push_back(b);
          rx_cyc_q.push_back(st);
          rx_par_q.push_back(p);
        end
      end
    end
  end

  // test sequence
  initial begin : main
    int          s;
    int          w_cyc;
    int          n;
    logic [31:0] words2 [6];
    logic [7:0]  t1_exp [4];
    logic [7:0]  t3_exp [4];

    words2 = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF,
               32'hF0E1D2C3, 32'h00FF00FF, 32'h5A5AA5A5};
    t1_exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    t3_exp = '{8'h5A, 8'hA5, 8'h96, 8'h3C};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_word_done", word_done, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_tx1", tx1, 1'b1);
    check("rst_fifo_count1", fifo_count1, 3'd0);
    check("rst_in_ready1", in_ready1, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single word, latency of word_done
    rx_byte_q.delete();
    rx_cyc_q.delete();
    push_word(32'h12345678);
    wait_tx_start(s);
    check("t1_busy_during", busy, 1'b1);
    n = 0;
    while (word_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t1_done_wait", (n < 400), 1'b1);
    w_cyc = cyc;
    check("t1_done_latency", w_cyc - s, WORD0);
    check("t1_busy_drop", busy, 1'b0);
    check("t1_tx_idle", tx, 1'b1);
    @(negedge clk);
    check("t1_done_pulse_width", word_done, 1'b0);
    repeat (2) @(negedge clk);
    check("t1_rx_count", rx_byte_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_byte_q.size(); i++)
      check($sformatf("t1_byte%0d", i), rx_byte_q[i], t1_exp[i]);
    for (int i = 1; i < rx_cyc_q.size(); i++)
      check($sformatf("t1_frame%0d", i), rx_cyc_q[i] - rx_cyc_q[i-1], FRAME0);
    check("t1_first_start", rx_cyc_q.size() > 0 ? rx_cyc_q[0] : -1, s);

    // 2: six words streamed, FIFO fills to four
    rx_byte_q.delete();
    rx_cyc_q.delete();
    for (int i = 0; i < 5; i++) push_word(words2[i]);
    @(negedge clk);
    check("t2_fifo_full_count", fifo_count, 3'd4);
    check("t2_in_ready_low", in_ready, 1'b0);
    push_word(words2[5]);
    wait_idle(2000);
    check("t2_rx_count", rx_byte_q.size(), 24);
    check("t2_sb_drained", exp_q.size(), 0);
    for (int i = 1; i < rx_cyc_q.size(); i++)
      check($sformatf("t2_gap%0d", i), rx_cyc_q[i] - rx_cyc_q[i-1], FRAME0);

    // 3: reset in the middle of the second byte
    push_word(32'hCAFE0001);
    wait_tx_start(s);
    push_word(32'h0BADF00D);
    while (cyc < s + FRAME0 + 19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t3_tx_after_reset", tx, 1'b1);
    check("t3_count_after_reset", fifo_count, 3'd0);
    check("t3_busy_after_reset", busy, 1'b0);
    check("t3_ready_after_reset", in_ready, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    repeat (FRAME0 + 4) @(negedge clk);
    check("t3_line_idle", tx, 1'b1);
    rx_byte_q.delete();
    push_word(32'h3C96A55A);
    wait_idle(400);
    check("t3_rx_count", rx_byte_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_byte_q.size(); i++)
      check($sformatf("t3_byte%0d", i), rx_byte_q[i], t3_exp[i]);

    // 4: two stop bits on dut1, every clock of the word checked
    @(negedge clk);
    in_data1  = 32'h000000FF;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx1 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_start_wait", (n < 20), 1'b1);
    for (int off = 0; off < 4 * FRAME1; off++) begin
      if (off != 0) @(negedge clk);
      check($sformatf("t4_tx_off%0d", off), tx1, exp_bit1(32'h000000FF, off));
    end
    @(negedge clk);
    check("t4_word_done", word_done1, 1'b1);
    check("t4_busy_drop", busy1, 1'b0);
    check("t4_tx_idle", tx1, 1'b1);

`ifdef UART_TX_PARITY_EN
    // 5: even parity bits 0,1,0,0 for bytes 78,01,00,00
    rx_par_q.delete();
    rx_cyc_q.delete();
    push_word(32'h00000178);
    wait_idle(400);
    check("t5_par_count", rx_par_q.size(), 4);
    if (rx_par_q.size() == 4) begin
      check("t5_par0", rx_par_q[0], 1'b0);
      check("t5_par1", rx_par_q[1], 1'b1);
      check("t5_par2", rx_par_q[2], 1'b0);
      check("t5_par3", rx_par_q[3], 1'b0);
    end
    for (int i = 1; i < rx_cyc_q.size(); i++)
      check($sformatf("t5_frame%0d", i), rx_cyc_q[i] - rx_cyc_q[i-1], 44);
`endif

    // 6: push offered while full on the edge that finishes a word
    rx_byte_q.delete();
    push_word(32'h11111111);
    wait_tx_start(s);
    push_word(32'h22222222);
    push_word(32'h33333333);
    push_word(32'h44444444);
    push_word(32'h55555555);
    while (cyc < s + WORD0 - 1) @(negedge clk);
    in_data  = 32'h99999999;
    in_valid = 1'b1;
    check("t6_ready_while_full", in_ready, 1'b0);
    check("t6_count_before", fifo_count, 3'd4);
    check("t6_done_before", word_done, 1'b0);
    @(negedge clk);
    check("t6_done_pulse", word_done, 1'b1);
    check("t6_ready_after", in_ready, 1'b1);
    check("t6_count_after_refused_push", fifo_count, 3'd3);
    in_valid = 1'b0;
    wait_idle(1200);
    check("t6_rx_count", rx_byte_q.size(), 20);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
